io_input_conditioner: RTL and testbench



---
 rtl/io_input_conditioner_pkg.sv | 8 +
 rtl/io_input_conditioner_if.sv | 26 ++
 rtl/io_input_conditioner_key_debounce.sv | 58 +++++
 rtl/io_input_conditioner.sv | 44 ++++
 tb/tb_io_input_conditioner.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/io_input_conditioner_pkg.sv
// rtl/io_input_conditioner_pkg.sv - shared constants for the SLC-3 board input conditioner
package slc3_io_pkg;

  localparam logic KEY_ACTIVE_LEVEL = 1'b0;
  localparam int   DEBOUNCE_DEFAULT = 50000;
  localparam int   SIM_DEBOUNCE     = 4;

endpackage

// File: rtl/io_input_conditioner_if.sv
// rtl/io_input_conditioner_if.sv - bundle of raw board inputs and conditioned outputs
interface io_input_conditioner_if;

  logic [9:0] SW_raw;
  logic [1:0] KEY_raw;
  logic [9:0] Switches;
  logic       Run_pulse;
  logic       Continue_pulse;

  modport master (
    output SW_raw,
    output KEY_raw,
    input  Switches,
    input  Run_pulse,
    input  Continue_pulse
  );

  modport slave (
    input  SW_raw,
    input  KEY_raw,
    output Switches,
    output Run_pulse,
    output Continue_pulse
  );

endinterface

// File: rtl/io_input_conditioner_key_debounce.sv
// rtl/io_input_conditioner_key_debounce.sv - one key: synchroniser, debounce counter, press pulse
module key_debounce
  import slc3_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_raw_i,
  output logic pulse_o
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;
  logic          pressed_sync;

  assign pressed_sync = (sync2_q == KEY_ACTIVE_LEVEL);

  // stable starts as pressed so a key held through reset cannot fire
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    pulse_d  = 1'b0;
    if (pressed_sync == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d = pressed_sync;
      cnt_d    = '0;
      pulse_d  = pressed_sync;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q  <= ~KEY_ACTIVE_LEVEL;
      sync2_q  <= ~KEY_ACTIVE_LEVEL;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
    end else begin
      sync1_q  <= key_raw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/io_input_conditioner.sv
// rtl/io_input_conditioner.sv - switch synchroniser plus Run/Continue key debouncers
module io_input_conditioner
  import slc3_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [9:0] SW_raw,
  input  logic [1:0] KEY_raw,
  output logic [9:0] Switches,
  output logic       Run_pulse,
  output logic       Continue_pulse
);

  logic [9:0] sw_sync1_q, sw_sync2_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sw_sync1_q <= '0;
      sw_sync2_q <= '0;
    end else begin
      sw_sync1_q <= SW_raw;
      sw_sync2_q <= sw_sync1_q;
    end
  end

  assign Switches = sw_sync2_q;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run (
    .clk_i     (Clk),
    .rst_i     (Reset),
    .key_raw_i (KEY_raw[0]),
    .pulse_o   (Run_pulse)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cont (
    .clk_i     (Clk),
    .rst_i     (Reset),
    .key_raw_i (KEY_raw[1]),
    .pulse_o   (Continue_pulse)
  );

endmodule

// File: tb/tb_io_input_conditioner.sv
// tb/tb_io_input_conditioner.sv - directed self-checking bench for io_input_conditioner
module tb_io_input_conditioner;
  import slc3_io_pkg::*;

  logic Clk;
  logic Reset;
  int   checks;
  int   errors;
  int   rc, cc, rfirst, cfirst, sw_bad;

  io_input_conditioner_if bus ();

  io_input_conditioner #(.DEBOUNCE_CYCLES(SIM_DEBOUNCE)) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .SW_raw         (bus.SW_raw),
    .KEY_raw        (bus.KEY_raw),
    .Switches       (bus.Switches),
    .Run_pulse      (bus.Run_pulse),
    .Continue_pulse (bus.Continue_pulse)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Runs n edges, counting pulses and recording the tick index of the first of each.
  task automatic watch(input int n, output int r_cnt, output int c_cnt,
                       output int r_first, output int c_first);
    r_cnt = 0; c_cnt = 0; r_first = 0; c_first = 0;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (bus.Run_pulse === 1'b1) begin
        r_cnt++;
        if (r_first == 0) r_first = i;
      end
      if (bus.Continue_pulse === 1'b1) begin
        c_cnt++;
        if (c_first == 0) c_first = i;
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    Reset = 1'b1;
    bus.SW_raw  = 10'h000;
    bus.KEY_raw = 2'b11;
    watch(3, rc, cc, rfirst, cfirst);
    check("reset_switches", {22'd0, bus.Switches}, 32'h0);
    check("reset_run_pulse", {31'd0, bus.Run_pulse}, 32'h0);
    check("reset_cont_pulse", {31'd0, bus.Continue_pulse}, 32'h0);
    check("reset_stable", {31'd0, dut.u_run.stable_q}, 32'h1);

    // released keys settle silently after reset
    Reset = 1'b0;
    sw_bad = 0;
    rc = 0; cc = 0;
    for (int i = 0; i < 10; i++) begin
      int r1, c1, f1, f2;
      watch(1, r1, c1, f1, f2);
      rc += r1;
      cc += c1;
      if (bus.Switches !== 10'h000) sw_bad++;
    end
    check("idle_run_pulses", rc, 0);
    check("idle_cont_pulses", cc, 0);
    check("idle_switches", sw_bad, 0);
    check("idle_run_stable", {31'd0, dut.u_run.stable_q}, 32'h0);
    check("idle_cont_stable", {31'd0, dut.u_cont.stable_q}, 32'h0);

    // switch latency: two edges
    bus.SW_raw = 10'h2A5;
    tick();
    check("sw_lat_k", {22'd0, bus.Switches}, 32'h0);
    tick();
    check("sw_lat_k1", {22'd0, bus.Switches}, 32'h2A5);
    bus.SW_raw = 10'h15A;
    tick();
    tick();
    check("sw_pattern2", {22'd0, bus.Switches}, 32'h15A);

    // clean Run press
    bus.KEY_raw = 2'b10;
    watch(20, rc, cc, rfirst, cfirst);
    check("run_press_count", rc, 1);
    check("run_press_time", rfirst, 6);
    check("run_press_cont", cc, 0);
    bus.KEY_raw = 2'b11;
    watch(20, rc, cc, rfirst, cfirst);
    check("run_release_count", rc, 0);

    // bouncy press 0,1,0,1 then held low
    rc = 0;
    for (int i = 0; i < 4; i++) begin
      int r1, c1, f1, f2;
      bus.KEY_raw = (i % 2 == 0) ? 2'b10 : 2'b11;
      watch(1, r1, c1, f1, f2);
      rc += r1;
    end
    check("bounce_early_pulses", rc, 0);
    bus.KEY_raw = 2'b10;
    watch(20, rc, cc, rfirst, cfirst);
    check("bounce_count", rc, 1);
    check("bounce_time", rfirst, 6);

    // short release (3 cycles) while held is ignored
    bus.KEY_raw = 2'b11;
    watch(3, rc, cc, rfirst, cfirst);
    bus.KEY_raw = 2'b10;
    watch(20, rc, cc, rfirst, cfirst);
    check("short_release_ignored", rc, 0);
    bus.KEY_raw = 2'b11;
    watch(20, rc, cc, rfirst, cfirst);

    // short press (3 cycles) is ignored
    bus.KEY_raw = 2'b10;
    watch(3, rc, cc, rfirst, cfirst);
    bus.KEY_raw = 2'b11;
    watch(1, rc, cc, rfirst, cfirst);
    begin
      int r2;
      r2 = rc;
      watch(20, rc, cc, rfirst, cfirst);
      check("short_press_ignored", r2 + rc, 0);
    end

    // Continue held through reset never fires until re-pressed
    Reset = 1'b1;
    bus.KEY_raw = 2'b01;
    watch(2, rc, cc, rfirst, cfirst);
    Reset = 1'b0;
    watch(20, rc, cc, rfirst, cfirst);
    check("held_reset_cont", cc, 0);
    bus.KEY_raw = 2'b11;
    watch(6, rc, cc, rfirst, cfirst);
    check("held_release_cont", cc, 0);
    bus.KEY_raw = 2'b01;
    watch(20, rc, cc, rfirst, cfirst);
    check("repress_cont_count", cc, 1);
    check("repress_cont_time", cfirst, 6);
    check("repress_run_count", rc, 0);
    bus.KEY_raw = 2'b11;
    watch(20, rc, cc, rfirst, cfirst);

    // simultaneous presses
    bus.KEY_raw = 2'b00;
    watch(20, rc, cc, rfirst, cfirst);
    check("both_run_count", rc, 1);
    check("both_cont_count", cc, 1);
    check("both_run_time", rfirst, 6);
    check("both_cont_time", cfirst, 6);
    bus.KEY_raw = 2'b11;
    watch(20, rc, cc, rfirst, cfirst);

    // reset while counter is mid-run
    bus.KEY_raw = 2'b10;
    watch(4, rc, cc, rfirst, cfirst);
    check("midcount_cnt", {30'd0, dut.u_run.cnt_q}, 32'h2);
    Reset = 1'b1;
    watch(1, rc, cc, rfirst, cfirst);
    check("midcount_cnt_cleared", {30'd0, dut.u_run.cnt_q}, 32'h0);
    check("midcount_stable_forced", {31'd0, dut.u_run.stable_q}, 32'h1);
    Reset = 1'b0;
    watch(15, rc, cc, rfirst, cfirst);
    check("midcount_no_pulse", rc, 0);
    bus.KEY_raw = 2'b11;
    watch(20, rc, cc, rfirst, cfirst);
    check("midcount_release_no_pulse", rc, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
